// File: rtl/ca1d_engine.sv
// One-dimensional cellular-automaton engine: seeds a WIDTH-cell generation and streams each
// generation as one frame-buffer row. Define CA1D_WRAP_EN for a toroidal (wrap-around) boundary.
module ca1d_engine #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        step,
  input  logic                        run,
  input  logic [7:0]                  rule,
  input  logic                        seed_mode,
  output logic                        we,
  output logic [ADDR_W-1:0]           addr,
  output logic                        data,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(HEIGHT)-1:0]   row,
  output logic [15:0]                 gen_count
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0]  COL_MID  = COL_W'(WIDTH / 2);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, INIT, WRITE, COMPUTE} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  cur_reg;
  logic [WIDTH-1:0]  cur_next;
  logic [COL_W-1:0]  col_reg;
  logic [COL_W-1:0]  col_inc;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] base_adv;
  logic [31:0]       lfsr_reg;
  logic              lfsr_fb;
  logic              seeded_reg;
  logic              seed_mode_reg;
  logic              edge_lo;
  logic              edge_hi;
  logic [WIDTH+1:0]  ext;

  assign col_inc  = col_reg + COL_W'(1);
  assign base_adv = (row == ROW_LAST) ? '0 : base_reg + ROW_STEP;
  assign lfsr_fb  = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];

`ifdef CA1D_WRAP_EN
  assign edge_lo = cur_reg[WIDTH-1];
  assign edge_hi = cur_reg[0];
`else
  assign edge_lo = 1'b0;
  assign edge_hi = 1'b0;
`endif

  // ext[i+1] is cell i; ext[0] and ext[WIDTH+1] are the virtual neighbours past each end.
  assign ext = {edge_hi, cur_reg, edge_lo};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic [2:0] nbr;
      assign nbr          = {ext[gi], ext[gi+1], ext[gi+2]};
      assign cur_next[gi] = rule[nbr];
    end
  endgenerate

  // Outputs are registered so they describe the state being occupied in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      col_reg       <= '0;
      base_reg      <= '0;
      lfsr_reg      <= 32'h1;
      seeded_reg    <= 1'b0;
      seed_mode_reg <= 1'b0;
      we            <= 1'b0;
      addr          <= '0;
      data          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row           <= '0;
      gen_count     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= INIT;
            seed_mode_reg <= seed_mode;
            col_reg       <= '0;
            row           <= '0;
            base_reg      <= '0;
            gen_count     <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
          end else if (step && seeded_reg) begin
            state_reg <= COMPUTE;
            busy      <= 1'b1;
          end
        end

        INIT: begin
          cur_reg[col_reg] <= seed_mode_reg ? lfsr_reg[0] : (col_reg == COL_MID);
          lfsr_reg         <= {lfsr_reg[30:0], lfsr_fb};
          if (col_reg == COL_LAST) begin
            seeded_reg <= 1'b1;
            state_reg  <= WRITE;
            col_reg    <= '0;
            we         <= 1'b1;
            addr       <= base_reg;
            data       <= cur_reg[0];
          end else begin
            col_reg <= col_inc;
          end
        end

        WRITE: begin
          if (col_reg == COL_LAST) begin
            col_reg <= '0;
            we      <= 1'b0;
            if (row == ROW_LAST) begin
              done <= 1'b1;
            end
            if (run && (row != ROW_LAST)) begin
              state_reg <= COMPUTE;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            col_reg <= col_inc;
            addr    <= addr + ADDR_W'(1);
            data    <= cur_reg[col_inc];
          end
        end

        COMPUTE: begin
          cur_reg   <= cur_next;
          row       <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
          base_reg  <= base_adv;
          gen_count <= gen_count + 16'd1;
          done      <= 1'b0;
          state_reg <= WRITE;
          col_reg   <= '0;
          we        <= 1'b1;
          addr      <= base_adv;
          data      <= cur_next[0];
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca1d_engine.sv
// Self-checking bench for ca1d_engine (WIDTH=8, HEIGHT=4) with a frame-buffer scoreboard
// and a generation-level CA / LFSR reference model.
module tb_ca1d_engine;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 5;
`ifdef CA1D_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, step, run, seed_mode;
  logic [7:0]    rule;
  logic          we, data, busy, done;
  logic [AW-1:0] addr;
  logic [1:0]    row;
  logic [15:0]   gen_count;

  ca1d_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .run(run), .rule(rule),
    .seed_mode(seed_mode), .we(we), .addr(addr), .data(data), .busy(busy), .done(done),
    .row(row), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         we_cnt = 0;
  logic       mem [0:(1<<AW)-1];
  logic [5:0] wlog [$];
  bit         lq [$];
  logic [7:0] model_cur;

  // Frame-buffer scoreboard: captures each write as the memory would.
  always @(posedge clk) begin
    if (we) begin
      mem[addr] = data;
      wlog.push_back({addr, data});
      we_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] row_of(input int r);
    logic [7:0] v;
    for (int c = 0; c < W; c++) v[c] = mem[r*W + c];
    return v;
  endfunction

  // Next generation from the neighbourhood-index definition of a Wolfram rule.
  function automatic logic [7:0] ca_step(input logic [7:0] c, input logic [7:0] rl);
    logic [7:0] n;
    int l, m, r, idx;
    for (int i = 0; i < W; i++) begin
      l = (i > 0) ? int'(c[i-1]) : (WRAP ? int'(c[W-1]) : 0);
      r = (i < W-1) ? int'(c[i+1]) : (WRAP ? int'(c[0]) : 0);
      m = int'(c[i]);
      idx = l*4 + m*2 + r;
      n[i] = rl[idx];
    end
    return n;
  endfunction

  // LFSR as the recurrence s[n] = s[n-1]^s[n-2]^s[n-22]^s[n-32], history newest last.
  task automatic model_reset();
    lq = {};
    for (int i = 0; i < 31; i++) lq.push_back(1'b0);
    lq.push_back(1'b1);
  endtask

  task automatic model_init(input bit sm);
    bit b, nb;
    for (int c = 0; c < W; c++) begin
      b  = lq[31];
      nb = lq[31] ^ lq[30] ^ lq[10] ^ lq[0];
      lq.push_back(nb);
      void'(lq.pop_front());
      model_cur[c] = sm ? b : (c == W/2);
    end
  endtask

  task automatic pulse(input bit s, input bit p);
    @(negedge clk);
    start = s;
    step  = p;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
  endtask

  task automatic do_start(input bit sm, input bit with_step);
    seed_mode = sm;
    pulse(1'b1, with_step);
    model_init(sm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Counts busy cycles from the cycle after the pulse edge; also reports first-we position.
  task automatic wait_idle(input int limit, output int busy_n, output int first_we);
    int i;
    i = 1;
    busy_n = 0;
    first_we = 0;
    while (busy && busy_n < limit) begin
      if (we && first_we == 0) first_we = i;
      busy_n++;
      @(negedge clk);
      i++;
    end
    if (busy_n >= limit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, limit);
    end
  endtask

  task automatic wait_we_addr(input logic [AW-1:0] a);
    int i;
    i = 0;
    while (!(we && addr == a) && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("wait_we_addr", 32'(i < 100), 32'd1);
  endtask

  typedef struct {
    logic [7:0] rule;
    logic [7:0] exp_row;
  } vec_t;

  initial begin
    vec_t       vecs [8];
    int         bn, fw, cnt0;
    logic [7:0] g, first_seed, exp_seq;

    vecs[0] = '{8'd90,  8'h28};
    vecs[1] = '{8'd30,  8'h38};
    vecs[2] = '{8'd102, 8'h18};
    vecs[3] = '{8'd4,   8'h10};
    vecs[4] = '{8'd254, 8'h38};
    vecs[5] = '{8'd0,   8'h00};
    vecs[6] = '{8'd255, 8'hFF};
    vecs[7] = '{8'd184, 8'h20};

    for (int i = 0; i < (1<<AW); i++) mem[i] = 1'b0;
    reset = 1'b1; start = 1'b0; step = 1'b0; run = 1'b0; rule = 8'd0; seed_mode = 1'b0;

    // Reset held 3 cycles with start pulsed during it
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_we", 32'(we), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_row", 32'(row), 0);
    check("rst_gen", 32'(gen_count), 0);
    cnt0 = we_cnt;
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("unseeded_step_we", 32'(we_cnt - cnt0), 0);
    check("unseeded_step_busy", 32'(busy), 0);
    $display("reset: outputs zero, unseeded step ignored");

    // Centre seed timing and data
    wlog = {};
    do_start(1'b0, 1'b0);
    wait_idle(100, bn, fw);
    check("centre_busy_cycles", 32'(bn), 2*W);
    check("centre_first_we", 32'(fw), W+1);
    check("centre_writes", 32'(wlog.size()), W);
    exp_seq = 8'h10;
    for (int i = 0; i < W && i < wlog.size(); i++) begin
      check("centre_addr", 32'(wlog[i][5:1]), 32'(i));
      check("centre_data", 32'(wlog[i][0]), 32'(exp_seq[i]));
    end
    $display("centre seed: row0=%h busy=%0d first_we=%0d", row_of(0), bn, fw);

    // Table: one step from the centre seed under each rule
    for (int v = 0; v < 8; v++) begin
      run = 1'b0;
      do_start(1'b0, 1'b0);
      wait_idle(100, bn, fw);
      rule = vecs[v].rule;
      pulse(1'b0, 1'b1);
      wait_idle(100, bn, fw);
      check("tbl_row1", 32'(row_of(1)), 32'(vecs[v].exp_row));
      check("tbl_step_busy", 32'(bn), W+1);
      check("tbl_step_first_we", 32'(fw), 2);
      check("tbl_gen", 32'(gen_count), 1);
      check("tbl_rowreg", 32'(row), 1);
      $display("vec %0d: rule=%0d row1=%h expect=%h", v, vecs[v].rule, row_of(1), vecs[v].exp_row);
    end

    // Rule 90 free-run to the last row
    rule = 8'd90;
    run  = 1'b1;
    do_start(1'b0, 1'b0);
    wait_idle(200, bn, fw);
    check("r90_row0", 32'(row_of(0)), 32'h10);
    check("r90_row1", 32'(row_of(1)), 32'h28);
    check("r90_row2", 32'(row_of(2)), 32'h44);
    check("r90_row3", 32'(row_of(3)), 32'hAA);
    check("r90_done", 32'(done), 1);
    check("r90_gen", 32'(gen_count), 3);
    check("r90_busy", 32'(busy), 0);
    check("r90_busy_cycles", 32'(bn), 2*W + (H-1)*(W+1));
    $display("rule90 run: rows %h %h %h %h done=%0b gen=%0d", row_of(0), row_of(1), row_of(2), row_of(3), done, gen_count);

    // Step after done wraps to row 0
    run = 1'b0;
    pulse(1'b0, 1'b1);
    wait_idle(100, bn, fw);
    check("wrap_row0", 32'(row_of(0)), WRAP ? 32'h00 : 32'h01);
    check("wrap_rowreg", 32'(row), 0);
    check("wrap_done", 32'(done), 0);
    check("wrap_gen", 32'(gen_count), 4);
    $display("wrap step: row0=%h wrap=%0b", row_of(0), WRAP);

    // LFSR seeding from the reset value
    do_reset();
    do_start(1'b1, 1'b0);
    wait_idle(100, bn, fw);
    first_seed = row_of(0);
    check("lfsr_golden", 32'(first_seed), 32'hDB);
    check("lfsr_model1", 32'(first_seed), 32'(model_cur));
    do_start(1'b1, 1'b0);
    wait_idle(100, bn, fw);
    check("lfsr_model2", 32'(row_of(0)), 32'(model_cur));
    check("lfsr_no_repeat", 32'(row_of(0) != first_seed), 1);
    $display("lfsr: seed1=%h seed2=%h", first_seed, row_of(0));

    // Randomized free-runs against the reference model
    for (int k = 0; k < 8; k++) begin
      rule = 8'($urandom_range(0, 255));
      run  = 1'b1;
      do_start(1'($urandom_range(0, 1)), 1'b0);
      wait_idle(200, bn, fw);
      g = model_cur;
      for (int r = 0; r < H; r++) begin
        check("rand_row", 32'(row_of(r)), 32'(g));
        g = ca_step(g, rule);
      end
      check("rand_done", 32'(done), 1);
      check("rand_gen", 32'(gen_count), 3);
      $display("rand %0d: rule=%0d seed_mode=%0b rows %h %h %h %h", k, rule, seed_mode, row_of(0), row_of(1), row_of(2), row_of(3));
    end
    run = 1'b0;

    // Step mid-WRITE is dropped, not queued
    do_start(1'b0, 1'b0);
    wait_we_addr(5'd2);
    pulse(1'b0, 1'b1);
    wait_idle(100, bn, fw);
    repeat (5) @(negedge clk);
    check("midwrite_step_busy", 32'(busy), 0);
    check("midwrite_step_gen", 32'(gen_count), 0);
    check("midwrite_row0", 32'(row_of(0)), 32'h10);
    $display("step during WRITE: gen=%0d busy=%0b", gen_count, busy);

    // Simultaneous start and step acts as start
    do_start(1'b0, 1'b1);
    wait_idle(100, bn, fw);
    check("startstep_busy", 32'(bn), 2*W);
    check("startstep_first_we", 32'(fw), W+1);
    check("startstep_gen", 32'(gen_count), 0);
    $display("start+step: busy=%0d first_we=%0d", bn, fw);

    // Reset during WRITE column 3 stops writes at once
    do_start(1'b0, 1'b0);
    wait_we_addr(5'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_we", 32'(we), 0);
    check("midreset_busy", 32'(busy), 0);
    reset = 1'b0;
    model_reset();
    cnt0 = we_cnt;
    repeat (10) @(negedge clk);
    check("midreset_no_writes", 32'(we_cnt - cnt0), 0);
    $display("reset at col 3: we=%0b busy=%0b", we, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
